pcoeff_result_accumulator: RTL



---
 rtl/pcoeff_result_accumulator.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pcoeff_result_accumulator.sv
// Per-batch accumulator of 2^connectCount over the count-connected result stream.
// Optional PCOEFF_CHECKSUM_EN adds a 16-bit rotate-xor checksum of the batch's connect counts.
module pcoeff_result_accumulator #(
   parameter int unsigned SUM_WIDTH   = 48,
   parameter int unsigned COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   resultValid,
   input  logic [5:0]             connectCount,
   input  logic                   isBatchEnd,
   input  logic                   eccStatus,
   input  logic                   sumReady,
   output logic                   sumValid,
   output logic [SUM_WIDTH-1:0]   sum,
   output logic [COUNT_WIDTH-1:0] validCount,
   output logic                   batchECC,
   output logic                   rangeError,
   output logic                   overflowError
`ifdef PCOEFF_CHECKSUM_EN
   ,
   output logic [15:0]            checksum
`endif
);

   logic                   in_range_c;
   logic [SUM_WIDTH-1:0]   term_c;

   logic                   s1_v;
   logic                   s1_last;
   logic                   s1_ecc;
   logic [SUM_WIDTH-1:0]   s1_term;

   logic [SUM_WIDTH-1:0]   acc_sum;
   logic [COUNT_WIDTH-1:0] acc_cnt;
   logic                   acc_ecc;

   logic [SUM_WIDTH-1:0]   sum_next_c;
   logic [COUNT_WIDTH-1:0] cnt_next_c;
   logic                   ecc_next_c;
   logic                   load_c;
   logic                   overflow_c;

   // Out-of-range counts contribute nothing but still count as valid beats.
   always_comb begin
      in_range_c = 32'(connectCount) < SUM_WIDTH;
      term_c     = '0;
      if (in_range_c)
         term_c = SUM_WIDTH'(1) << connectCount;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v       <= 1'b0;
         s1_last    <= 1'b0;
         s1_ecc     <= 1'b0;
         s1_term    <= '0;
         rangeError <= 1'b0;
      end else begin
         s1_v    <= resultValid;
         s1_last <= resultValid & isBatchEnd;
         s1_ecc  <= eccStatus;
         s1_term <= term_c;
         if (resultValid && !in_range_c)
            rangeError <= 1'b1;
      end
   end

   // Running totals including the beat currently in stage 2.
   always_comb begin
      sum_next_c = acc_sum;
      cnt_next_c = acc_cnt;
      ecc_next_c = acc_ecc | s1_ecc;
      if (s1_v) begin
         sum_next_c = acc_sum + s1_term;
         if (!(&acc_cnt))
            cnt_next_c = acc_cnt + COUNT_WIDTH'(1);
      end
      load_c     = s1_last && (!sumValid || sumReady);
      overflow_c = s1_last && sumValid && !sumReady;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_sum       <= '0;
         acc_cnt       <= '0;
         acc_ecc       <= 1'b0;
         sumValid      <= 1'b0;
         sum           <= '0;
         validCount    <= '0;
         batchECC      <= 1'b0;
         overflowError <= 1'b0;
      end else begin
         if (s1_last) begin
            acc_sum <= '0;
            acc_cnt <= '0;
            acc_ecc <= 1'b0;
         end else begin
            acc_sum <= sum_next_c;
            acc_cnt <= cnt_next_c;
            acc_ecc <= ecc_next_c;
         end

         if (load_c) begin
            sumValid   <= 1'b1;
            sum        <= sum_next_c;
            validCount <= cnt_next_c;
            batchECC   <= ecc_next_c;
         end else if (sumValid && sumReady) begin
            sumValid <= 1'b0;
         end

         if (overflow_c)
            overflowError <= 1'b1;
      end
   end

`ifdef PCOEFF_CHECKSUM_EN
   logic [5:0]  s1_cc;
   logic [15:0] acc_chk;
   logic [15:0] chk_next_c;

   always_comb begin
      chk_next_c = acc_chk;
      if (s1_v)
         chk_next_c = {acc_chk[14:0], acc_chk[15]} ^ {10'b0, s1_cc};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_cc    <= '0;
         acc_chk  <= '0;
         checksum <= '0;
      end else begin
         s1_cc   <= connectCount;
         acc_chk <= s1_last ? 16'h0000 : chk_next_c;
         if (load_c)
            checksum <= chk_next_c;
      end
   end
`endif

endmodule
